// File: rtl/data_mem_resp_pkg.sv
// Shared types and constants for the latency-modelled data memory responder.
package data_mem_resp_pkg;

  localparam int unsigned LATENCY_DEF = 2;
  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BUS_AW      = 16;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Exactly one direction and a half-word aligned address.
  function automatic logic req_legal(input logic rd, input logic wr, input logic a0);
    return (rd ^ wr) & ~a0;
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Request/response bus between an initiator and the data memory responder.
interface data_mem_resp_if;
  import data_mem_resp_pkg::*;

  logic [BUS_AW-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] data_out;
  logic              stall;
  logic              done;
  logic              err;

  modport master (output addr, data_in, rd, wr, input  data_out, stall, done, err);
  modport slave  (input  addr, data_in, rd, wr, output data_out, stall, done, err);

endinterface

// File: rtl/data_mem_resp_array.sv
// Single-port word storage: synchronous write, asynchronous read, never reset.
module data_mem_resp_array
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_resp.sv
// Memory responder: accepts one aligned rd/wr in IDLE, stalls LATENCY cycles,
// then pulses done; malformed requests produce a one-cycle err pulse.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_resp_if.slave bus
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] widx_q;
  logic [ADDR_W-1:0] widx_d;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] rdata;
  logic              is_wr_q;
  logic              stall_q;
  logic              done_q;
  logic              err_q;
  logic              mem_we;

  assign widx_d = bus.addr[ADDR_W:1];

  // Commit at the end of DONE unless that same edge is a reset.
  assign mem_we = (state_q == S_DONE) && is_wr_q && rst;

  data_mem_resp_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (widx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      dout_q  <= '0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.rd || bus.wr) begin
            if (req_legal(bus.rd, bus.wr, bus.addr[0])) begin
              widx_q  <= widx_d;
              wdata_q <= bus.data_in;
              is_wr_q <= bus.wr;
              cnt_q   <= CNT_W'(LATENCY - 1);
              stall_q <= 1'b1;
              state_q <= S_WAIT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
            if (!is_wr_q) begin
              dout_q <= rdata;
            end
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
            stall_q <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out = dout_q;
  assign bus.stall    = stall_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench: three responders (LATENCY 2, 1, 15) against a cycle/memory model.
module tb_data_mem_resp;
  import data_mem_resp_pkg::*;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;
  localparam int LAT_C = 15;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  int          sel = 0;

  always #5 clk = ~clk;

  data_mem_resp_if bus_a ();
  data_mem_resp_if bus_b ();
  data_mem_resp_if bus_c ();

  assign bus_a.addr = addr;  assign bus_a.data_in = data_in;
  assign bus_b.addr = addr;  assign bus_b.data_in = data_in;
  assign bus_c.addr = addr;  assign bus_c.data_in = data_in;
  assign bus_a.rd = rd && (sel == 0);  assign bus_a.wr = wr && (sel == 0);
  assign bus_b.rd = rd && (sel == 1);  assign bus_b.wr = wr && (sel == 1);
  assign bus_c.rd = rd && (sel == 2);  assign bus_c.wr = wr && (sel == 2);

  data_mem_resp #(.LATENCY(LAT_A), .ADDR_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  data_mem_resp #(.LATENCY(LAT_B), .ADDR_W(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  data_mem_resp #(.LATENCY(LAT_C), .ADDR_W(8)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  logic [15:0] o_dout;
  logic        o_stall, o_done, o_err;

  always_comb begin
    o_dout = bus_a.data_out; o_stall = bus_a.stall; o_done = bus_a.done; o_err = bus_a.err;
    case (sel)
      1: begin o_dout = bus_b.data_out; o_stall = bus_b.stall; o_done = bus_b.done; o_err = bus_b.err; end
      2: begin o_dout = bus_c.data_out; o_stall = bus_c.stall; o_done = bus_c.done; o_err = bus_c.err; end
      default: ;
    endcase
  end

  int errors = 0;
  int checks = 0;

  logic [15:0] mem_m  [3][DEPTH];
  bit          vld_m  [3][DEPTH];
  logic [15:0] dout_m [3];
  bit          dout_k [3];

  function automatic int lat_of(input int s);
    return (s == 0) ? LAT_A : (s == 1) ? LAT_B : LAT_C;
  endfunction

  function automatic int word_of(input logic [15:0] a);
    return (int'(a) / 2) % DEPTH;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin dout_m[s] = 16'h0000; dout_k[s] = 1'b1; end
  endtask

  // One legal access on the selected DUT, checking every cycle until the IDLE after done.
  task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d, input bit tog);
    int lat;
    int idx;
    lat = lat_of(sel);
    idx = word_of(a);
    @(negedge clk);
    addr = a; data_in = d; wr = w; rd = !w;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      checks++;
      if (o_stall !== (c <= lat)) begin errors++;
        $display("FAIL stall s%0d a=%h c%0d: got %b want %b", sel, a, c, o_stall, (c <= lat)); end
      checks++;
      if (o_done !== (c == lat + 1)) begin errors++;
        $display("FAIL done s%0d a=%h c%0d: got %b want %b", sel, a, c, o_done, (c == lat + 1)); end
      checks++;
      if (o_err !== 1'b0) begin errors++;
        $display("FAIL err_in_access s%0d a=%h c%0d: got %b want 0", sel, a, c, o_err); end
      if (c == lat + 1) begin
        if (!w) begin
          if (vld_m[sel][idx]) begin
            checks++;
            if (o_dout !== mem_m[sel][idx]) begin errors++;
              $display("FAIL rdata s%0d a=%h: got %h want %h", sel, a, o_dout, mem_m[sel][idx]); end
            dout_m[sel] = mem_m[sel][idx];
            dout_k[sel] = 1'b1;
          end else begin
            dout_k[sel] = 1'b0;
          end
        end else if (dout_k[sel]) begin
          checks++;
          if (o_dout !== dout_m[sel]) begin errors++;
            $display("FAIL wr_dout s%0d a=%h: got %h want %h", sel, a, o_dout, dout_m[sel]); end
        end
        rd = 1'b0; addr = a;
      end else begin
        if (tog) begin
          rd   = 1'($urandom_range(0, 1));
          addr = 16'($urandom) & 16'hFFFE;
        end
        @(negedge clk);
      end
    end
    if (w) begin mem_m[sel][idx] = d; vld_m[sel][idx] = 1'b1; end
    @(negedge clk);
    checks++;
    if ({o_stall, o_done, o_err} !== 3'b000) begin errors++;
      $display("FAIL idle_after s%0d a=%h: got s/d/e=%b want 000", sel, a, {o_stall, o_done, o_err}); end
    if (dout_k[sel]) begin
      checks++;
      if (o_dout !== dout_m[sel]) begin errors++;
        $display("FAIL dout_hold s%0d a=%h: got %h want %h", sel, a, o_dout, dout_m[sel]); end
    end
  endtask

  task automatic reject(input logic [15:0] a, input bit r, input bit w);
    @(negedge clk);
    addr = a; rd = r; wr = w;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    checks++;
    if ({o_stall, o_done, o_err} !== 3'b001) begin errors++;
      $display("FAIL reject_pulse s%0d a=%h rw=%b%b: got s/d/e=%b want 001", sel, a, r, w, {o_stall, o_done, o_err}); end
    @(negedge clk);
    checks++;
    if ({o_stall, o_done, o_err} !== 3'b000) begin errors++;
      $display("FAIL reject_after s%0d a=%h: got s/d/e=%b want 000", sel, a, {o_stall, o_done, o_err}); end
    if (dout_k[sel]) begin
      checks++;
      if (o_dout !== dout_m[sel]) begin errors++;
        $display("FAIL reject_dout s%0d a=%h: got %h want %h", sel, a, o_dout, dout_m[sel]); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rd = 1'b0; wr = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if ({o_stall, o_done, o_err} !== 3'b000 || o_dout !== 16'h0000) begin errors++;
        $display("FAIL reset_state s%0d: got s/d/e=%b dout=%h want 000 0000", s, {o_stall, o_done, o_err}, o_dout); end
    end
    sel = 0;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    sel = 0;
    access(1'b1, 16'h0010, 16'hBEEF, 1'b0);
    access(1'b0, 16'h0010, 16'h0000, 1'b0);
  endtask

  task automatic test_errors();
    sel = 0;
    access(1'b1, 16'h0004, 16'h7E57, 1'b0);
    reject(16'h0004, 1'b1, 1'b1);
    reject(16'h0003, 1'b1, 1'b0);
    reject(16'h0005, 1'b0, 1'b1);
    access(1'b0, 16'h0004, 16'h0000, 1'b0);
    access(1'b1, 16'h0202, 16'h1234, 1'b0);
    access(1'b0, 16'h0002, 16'h0000, 1'b0);
  endtask

  // Reset during WAIT (cycle 2) and during DONE (cycle 3) must drop the write.
  task automatic test_reset_mid();
    sel = 0;
    for (int k = 0; k < 2; k++) begin
      logic [15:0] a;
      logic [15:0] keep;
      a    = (k == 0) ? 16'h0020 : 16'h0030;
      keep = (k == 0) ? 16'h5555 : 16'h600D;
      access(1'b1, a, keep, 1'b0);
      @(negedge clk);
      addr = a; data_in = (k == 0) ? 16'hAAAA : 16'hDEAD; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
      @(negedge clk);
      if (k == 1) begin
        @(negedge clk);
        checks++;
        if (o_done !== 1'b1) begin errors++;
          $display("FAIL pre_reset_done: got %b want 1", o_done); end
      end
      rst = 1'b0;
      @(negedge clk);
      model_reset();
      checks++;
      if ({o_stall, o_done, o_err} !== 3'b000 || o_dout !== 16'h0000) begin errors++;
        $display("FAIL midreset_state k%0d: got s/d/e=%b dout=%h want 000 0000", k, {o_stall, o_done, o_err}, o_dout); end
      rst = 1'b1;
      access(1'b0, a, 16'h0000, 1'b0);
    end
  endtask

  task automatic test_latency();
    for (int s = 1; s < 3; s++) begin
      logic [15:0] d;
      sel = s;
      d = 16'($urandom);
      access(1'b1, 16'h0066, d, 1'b1);
      access(1'b0, 16'h0066, 16'h0000, 1'b1);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int n = 0; n < 20; n++) begin
        int          op;
        logic [15:0] a;
        op = int'($urandom_range(0, 5));
        a  = 16'($urandom) & 16'hFE1E;
        if (op <= 1)      access(1'b1, a, 16'($urandom), 1'($urandom_range(0, 1)));
        else if (op <= 4) access(1'b0, a, 16'h0000, 1'($urandom_range(0, 1)));
        else if (op == 5 && n[0]) reject(a | 16'h0001, 1'($urandom_range(0, 1)), 1'b1);
        else              reject(a, 1'b1, 1'b1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int done_cyc [$];
    sel = 0;
    access(1'b1, 16'h0040, 16'hC0DE, 1'b0);
    @(negedge clk);
    addr = 16'h0040; rd = 1'b1;
    for (int c = 0; c < 40 && done_cyc.size() < 4; c++) begin
      @(negedge clk);
      checks++;
      if (int'(o_stall) + int'(o_done) + int'(o_err) > 1) begin errors++;
        $display("FAIL exclusive c%0d: got s/d/e=%b want at most one", c, {o_stall, o_done, o_err}); end
      if (o_done) begin
        done_cyc.push_back(c);
        checks++;
        if (o_dout !== 16'hC0DE) begin errors++;
          $display("FAIL b2b_data c%0d: got %h want c0de", c, o_dout); end
      end
    end
    rd = 1'b0;
    checks++;
    if (done_cyc.size() != 4) begin errors++;
      $display("FAIL b2b_count: got %0d done pulses want 4", done_cyc.size()); end
    for (int i = 1; i < done_cyc.size(); i++) begin
      checks++;
      if (done_cyc[i] - done_cyc[i-1] != LAT_A + 2) begin errors++;
        $display("FAIL b2b_period i%0d: got %0d want %0d", i, done_cyc[i] - done_cyc[i-1], LAT_A + 2); end
    end
    dout_m[0] = 16'hC0DE; dout_k[0] = 1'b1;
    repeat (LAT_A + 3) @(negedge clk);
  endtask

  initial begin
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < DEPTH; i++) vld_m[s][i] = 1'b0;
    test_reset();
    test_basic();
    test_errors();
    test_reset_mid();
    test_latency();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
